i_mem_axi_slave: RTL and testbench

I_MEM_AXI_SLAVE -- requirements
Module: i_mem_axi_slave

---
 rtl/i_mem_axi_pkg.sv | 23 ++
 rtl/i_mem_sp_ram.sv | 32 +++
 rtl/i_mem_axi_slave.sv | 133 +++++++++++++
 tb/tb_i_mem_axi_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/i_mem_axi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | i_mem_axi_pkg : shared types/constants for the AXI instruction-memory    |
// | slave.                                          Revision: 1.0            |
// +--------------------------------------------------------------------------+
package i_mem_axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int beat_cnt_width(input int n_word);
    return (n_word > 1) ? $clog2(n_word) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i_mem_sp_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | i_mem_sp_ram : word-wide storage, one sync write port and one sync read  |
// | port with 1-cycle latency; contents are never reset.  Revision: 1.0      |
// +--------------------------------------------------------------------------+
module i_mem_sp_ram #(
  parameter int WIDTH_DATA = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_waddr,
  input  logic [WIDTH_DATA-1:0]        i_wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_raddr,
  output logic [WIDTH_DATA-1:0]        o_rdata
);

  logic [WIDTH_DATA-1:0] r_mem [MEM_DEPTH];
  logic [WIDTH_DATA-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/i_mem_axi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | i_mem_axi_slave : AXI read-only slave serving cache-line INCR bursts     |
// | from a preloadable instruction memory.          Revision: 1.0            |
// +--------------------------------------------------------------------------+
module i_mem_axi_slave #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADD  = 32,
  parameter int N_WORD     = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         AXI_CLK,
  input  logic                         AXI_RESETn,
  input  logic                         AXI_ARVALID,
  output logic                         AXI_ARREADY,
  input  logic [WIDTH_ADD-1:0]         AXI_ARADDR,
  input  logic [2:0]                   AXI_ARPROT,
  input  logic [3:0]                   AXI_ARCACHE,
  output logic                         AXI_RVALID,
  input  logic                         AXI_RREADY,
  output logic [WIDTH_DATA-1:0]        AXI_RDATA,
  output logic [1:0]                   AXI_RRESP,
  output logic                         AXI_RLAST,
  input  logic                         LD_EN,
  input  logic [$clog2(MEM_DEPTH)-1:0] LD_ADDR,
  input  logic [WIDTH_DATA-1:0]        LD_DATA
);
  import i_mem_axi_pkg::*;

  localparam int CNT_W  = beat_cnt_width(N_WORD);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int IDX_W  = WIDTH_ADD - 2;
  localparam int SUM_W  = IDX_W + 1;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_base;
  logic                  r_decerr;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_last_beat;
  logic                  w_ld_we;
  logic [IDX_W-1:0]      w_ar_base;
  logic                  w_ar_decerr;
  logic [CNT_W-1:0]      w_rd_beat;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic [WIDTH_DATA-1:0] w_ram_q;
  logic                  w_unused;

  assign w_ar_base   = AXI_ARADDR[WIDTH_ADD-1:2] & ~IDX_W'(N_WORD - 1);
  assign w_ar_decerr = ({1'b0, w_ar_base} + SUM_W'(N_WORD - 1)) >= SUM_W'(MEM_DEPTH);

  assign w_ar_hs     = AXI_ARVALID && AXI_ARREADY;
  assign w_r_hs      = (r_state == BURST) && AXI_RREADY;
  assign w_last_beat = (r_cnt == CNT_W'(N_WORD - 1));
  assign w_ld_we     = LD_EN && (r_state == IDLE);

  // Look one beat ahead on a handshake so the RAM latency never costs a cycle;
  // while stalled the same word is re-read, which keeps RDATA stable.
  assign w_rd_beat = w_r_hs ? (r_cnt + CNT_W'(1)) : r_cnt;
  assign w_rd_idx  = r_base + IDX_W'(w_rd_beat);
  assign w_rd_addr = w_rd_idx[ADDR_W-1:0];

  assign w_unused = ^{AXI_ARPROT, AXI_ARCACHE, AXI_ARADDR[1:0], w_rd_idx};

  always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
    if (!AXI_RESETn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_base   <= '0;
      r_decerr <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_ar_hs) begin
        r_base   <= w_ar_base;
        r_decerr <= w_ar_decerr;
        r_cnt    <= '0;
      end else if (w_r_hs) begin
        r_cnt <= w_last_beat ? '0 : (r_cnt + CNT_W'(1));
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    AXI_ARREADY  = 1'b0;
    AXI_RVALID   = 1'b0;
    AXI_RDATA    = '0;
    AXI_RRESP    = RESP_OKAY;
    AXI_RLAST    = 1'b0;
    case (r_state)
      IDLE: begin
        AXI_ARREADY = !LD_EN;
        if (w_ar_hs) begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        w_next_state = BURST;
      end
      BURST: begin
        AXI_RVALID = 1'b1;
        AXI_RDATA  = r_decerr ? '0 : w_ram_q;
        AXI_RRESP  = r_decerr ? RESP_DECERR : RESP_OKAY;
        AXI_RLAST  = w_last_beat;
        if (w_r_hs && w_last_beat) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  i_mem_sp_ram #(
    .WIDTH_DATA (WIDTH_DATA),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (AXI_CLK),
    .i_we    (w_ld_we),
    .i_waddr (LD_ADDR),
    .i_wdata (LD_DATA),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_i_mem_axi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i_mem_axi_slave : directed + random bursts against a memory model.    |
// |                                                 Revision: 1.0            |
// +--------------------------------------------------------------------------+
module tb_i_mem_axi_slave;

  localparam int WD    = 32;
  localparam int WA    = 32;
  localparam int NW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          AXI_CLK = 1'b0;
  logic          AXI_RESETn = 1'b0;
  logic          AXI_ARVALID = 1'b0;
  logic          AXI_ARREADY;
  logic [WA-1:0] AXI_ARADDR = '0;
  logic [2:0]    AXI_ARPROT = '0;
  logic [3:0]    AXI_ARCACHE = '0;
  logic          AXI_RVALID;
  logic          AXI_RREADY = 1'b0;
  logic [WD-1:0] AXI_RDATA;
  logic [1:0]    AXI_RRESP;
  logic          AXI_RLAST;
  logic          LD_EN = 1'b0;
  logic [AW-1:0] LD_ADDR = '0;
  logic [WD-1:0] LD_DATA = '0;

  logic [31:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_err    = 0;

  always #5 AXI_CLK = ~AXI_CLK;

  i_mem_axi_slave #(
    .WIDTH_DATA (WD),
    .WIDTH_ADD  (WA),
    .N_WORD     (NW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .AXI_CLK     (AXI_CLK),
    .AXI_RESETn  (AXI_RESETn),
    .AXI_ARVALID (AXI_ARVALID),
    .AXI_ARREADY (AXI_ARREADY),
    .AXI_ARADDR  (AXI_ARADDR),
    .AXI_ARPROT  (AXI_ARPROT),
    .AXI_ARCACHE (AXI_ARCACHE),
    .AXI_RVALID  (AXI_RVALID),
    .AXI_RREADY  (AXI_RREADY),
    .AXI_RDATA   (AXI_RDATA),
    .AXI_RRESP   (AXI_RRESP),
    .AXI_RLAST   (AXI_RLAST),
    .LD_EN       (LD_EN),
    .LD_ADDR     (LD_ADDR),
    .LD_DATA     (LD_DATA)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a line is the N_WORD-aligned word group holding the byte address.
  function automatic int line_base(input logic [31:0] addr);
    return int'(addr >> 2) / NW * NW;
  endfunction

  function automatic bit line_decerr(input logic [31:0] addr);
    return (line_base(addr) + NW - 1) >= DEPTH;
  endfunction

  function automatic logic [31:0] exp_beat(input logic [31:0] addr, input int i);
    if (line_decerr(addr)) return 32'h0;
    return model_mem[line_base(addr) + i];
  endfunction

  task automatic issue_ar(input logic [31:0] addr);
    AXI_ARVALID = 1'b1;
    AXI_ARADDR  = addr;
    #1;
    check("arready_idle", {31'b0, AXI_ARREADY}, 32'd1);
    @(negedge AXI_CLK);
    AXI_ARVALID = 1'b0;
    AXI_ARADDR  = $urandom;
  endtask

  // Entered on the negedge right after the AR handshake edge.
  task automatic read_beats(input logic [31:0] addr, input int mode,
                            input int abort_after, input bit ld_during);
    int beats = 0;
    int cyc   = 0;
    logic [3:0] pat = 4'b1001;
    logic rr;
    check("rvalid_fetch", {31'b0, AXI_RVALID}, 32'd0);
    @(negedge AXI_CLK);
    check("rvalid_first", {31'b0, AXI_RVALID}, 32'd1);
    while (beats < NW) begin
      if (cyc >= 200) begin
        n_checks++;
        n_err++;
        $error("FAIL burst_timeout observed=%0d beats expected=%0d", beats, NW);
        break;
      end
      if (abort_after > 0 && beats == abort_after) begin
        AXI_RESETn = 1'b0;
        AXI_RREADY = 1'b0;
        #1;
        check("rst_rvalid",  {31'b0, AXI_RVALID}, 32'd0);
        check("rst_rlast",   {31'b0, AXI_RLAST}, 32'd0);
        check("rst_rdata",   AXI_RDATA, 32'd0);
        check("rst_rresp",   {30'b0, AXI_RRESP}, 32'd0);
        check("rst_arready", {31'b0, AXI_ARREADY}, 32'd1);
        @(negedge AXI_CLK);
        AXI_RESETn = 1'b1;
        #1;
        check("post_rst_arready", {31'b0, AXI_ARREADY}, 32'd1);
        return;
      end
      if (ld_during && cyc == 0) begin
        LD_EN   = 1'b1;
        LD_ADDR = AW'(line_base(addr) + 5);
        LD_DATA = ~model_mem[line_base(addr) + 5];
      end else begin
        LD_EN = 1'b0;
      end
      case (mode)
        0:       rr = 1'b1;
        1:       rr = pat[cyc % 4];
        default: rr = 1'($urandom_range(1, 0));
      endcase
      check("rvalid_burst",  {31'b0, AXI_RVALID}, 32'd1);
      check("arready_burst", {31'b0, AXI_ARREADY}, 32'd0);
      check("rdata",  AXI_RDATA, exp_beat(addr, beats));
      check("rresp",  {30'b0, AXI_RRESP}, line_decerr(addr) ? 32'd3 : 32'd0);
      check("rlast",  {31'b0, AXI_RLAST}, (beats == NW - 1) ? 32'd1 : 32'd0);
      AXI_RREADY  = rr;
      AXI_ARVALID = (mode == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
      if (rr) beats++;
      cyc++;
      @(negedge AXI_CLK);
    end
    AXI_RREADY  = 1'b0;
    AXI_ARVALID = 1'b0;
    LD_EN       = 1'b0;
    #1;
    check("rvalid_done",  {31'b0, AXI_RVALID}, 32'd0);
    check("arready_done", {31'b0, AXI_ARREADY}, 32'd1);
  endtask

  initial begin
    #12;
    check("reset_rvalid",  {31'b0, AXI_RVALID}, 32'd0);
    check("reset_arready", {31'b0, AXI_ARREADY}, 32'd1);
    check("reset_rlast",   {31'b0, AXI_RLAST}, 32'd0);
    check("reset_rdata",   AXI_RDATA, 32'd0);
    check("reset_rresp",   {30'b0, AXI_RRESP}, 32'd0);
    @(negedge AXI_CLK);
    AXI_RESETn = 1'b1;

    // Preload every word so no read ever returns uninitialised data.
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = (i >= 8 && i < 16) ? (32'h1000_0000 + 32'(i)) : $urandom;
      LD_EN   = 1'b1;
      LD_ADDR = AW'(i);
      LD_DATA = model_mem[i];
      @(negedge AXI_CLK);
    end
    LD_EN = 1'b0;

    issue_ar(32'h0000_0020); read_beats(32'h0000_0020, 0, 0, 0);
    issue_ar(32'h0000_002C); read_beats(32'h0000_002C, 0, 0, 0);
    issue_ar(32'h0000_0020); read_beats(32'h0000_0020, 1, 0, 0);
    issue_ar(32'h0000_1000); read_beats(32'h0000_1000, 0, 0, 0);
    issue_ar(32'h0000_0FE4); read_beats(32'h0000_0FE4, 1, 0, 0);

    // Load and request in the same idle cycle: the load wins, AR waits.
    LD_EN       = 1'b1;
    LD_ADDR     = AW'(18);
    LD_DATA     = 32'hCAFE_0012;
    AXI_ARVALID = 1'b1;
    AXI_ARADDR  = 32'h0000_0040;
    #1;
    check("arready_ld_block", {31'b0, AXI_ARREADY}, 32'd0);
    model_mem[18] = 32'hCAFE_0012;
    @(negedge AXI_CLK);
    LD_EN = 1'b0;
    #1;
    check("arready_after_ld", {31'b0, AXI_ARREADY}, 32'd1);
    @(negedge AXI_CLK);
    AXI_ARVALID = 1'b0;
    read_beats(32'h0000_0040, 0, 0, 0);

    // A load during a burst must be dropped; the re-read proves it.
    issue_ar(32'h0000_0060); read_beats(32'h0000_0060, 0, 0, 1);
    issue_ar(32'h0000_0060); read_beats(32'h0000_0060, 0, 0, 0);

    issue_ar(32'h0000_0020); read_beats(32'h0000_0020, 0, 3, 0);
    issue_ar(32'h0000_0020); read_beats(32'h0000_0020, 0, 0, 0);

    for (int k = 0; k < 12; k++) begin
      logic [31:0] a;
      a = $urandom_range(32'h0000_1100, 0);
      issue_ar(a);
      read_beats(a, 2, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
